// File: rtl/iterative_shift_unit.sv
// iterative_shift_unit
// Multi-cycle shifter for the execute stage. An accepted request loads the
// operand, the shift count and the operation. The unit then moves the
// accumulator one bit position per clock until the count reaches zero.
// It then writes Result and pulses Done for one cycle. Busy lets the control
// unit stall the PC and write-back while an operation is in flight.
// All outputs come straight from flops, so no input reaches an output
// combinationally.

module iterative_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Start,
    input  logic [WIDTH-1:0]   Shift_Data,
    input  logic [SHAMT_W-1:0] Shift_Amount,
    input  logic [1:0]         Shift_Op,
    input  logic               Flush,
    output logic               Busy,
    output logic               Done,
    output logic [WIDTH-1:0]   Result
);

    // Operation encodings as presented on Shift_Op
    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTL = 2'b11;

    localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
    localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ACC_ZERO = {WIDTH{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // One-bit step of the accumulator for the captured operation.
    // Bits shifted out are dropped, except for rotate-left, which wraps
    // the MSB around into bit 0.
    function automatic logic [WIDTH-1:0] shift_one(
        input logic [WIDTH-1:0] acc,
        input logic [1:0]       op
    );
        logic [WIDTH-1:0] res;
        case (op)
            OP_SLL:  res = {acc[WIDTH-2:0], 1'b0};
            OP_SRL:  res = {1'b0, acc[WIDTH-1:1]};
            OP_SRA:  res = {acc[WIDTH-1], acc[WIDTH-1:1]};
            OP_ROTL: res = {acc[WIDTH-2:0], acc[WIDTH-1]};
            default: res = acc;
        endcase
        return res;
    endfunction

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   acc_q,    acc_d;
    logic [SHAMT_W-1:0] cnt_q,    cnt_d;
    logic [1:0]         op_q,     op_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               done_q,   done_d;
    logic               busy_q,   busy_d;

    // Next-state, datapath step and output computation.
    // Flush takes priority over both a new request and completion.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        done_d   = 1'b0;

        if (Flush) begin
            // Abort: drop back to idle and leave Result untouched
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        acc_d   = Shift_Data;
                        cnt_d   = Shift_Amount;
                        op_d    = Shift_Op;
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    // Start is deliberately ignored here; there is no queue
                    if (cnt_q != CNT_ZERO) begin
                        acc_d = shift_one(acc_q, op_q);
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        // Count exhausted: publish the accumulator
                        result_d = acc_q;
                        done_d   = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_SHIFT);
    end

    // State, datapath and output registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= ACC_ZERO;
            cnt_q    <= CNT_ZERO;
            op_q     <= OP_SLL;
            result_q <= ACC_ZERO;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign Busy   = busy_q;
    assign Done   = done_q;
    assign Result = result_q;

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Directed bench for iterative_shift_unit: hand-computed vectors for each
// operation, count boundaries, handshake corner cases, flush and reset.

module tb_iterative_shift_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] shift_data;
    logic [4:0]  shift_amount;
    logic [1:0]  shift_op;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_mis = 0;

    iterative_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .Clk          (clk),
        .Reset_n      (reset_n),
        .Start        (start),
        .Shift_Data   (shift_data),
        .Shift_Amount (shift_amount),
        .Shift_Op     (shift_op),
        .Flush        (flush),
        .Busy         (busy),
        .Done         (done),
        .Result       (result)
    );

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Tick until Done is seen or the budget runs out; cyc counts ticks
    // since the accepting edge, starting from cyc_in.
    task automatic wait_done(input int cyc_in, output int cyc);
        cyc = cyc_in;
        while (done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    // Issue one request, then check Busy, latency, Result and Busy in the Done cycle.
    // Returns in the Done cycle so the next call can start back-to-back.
    task automatic run_op(input logic [31:0] data, input logic [4:0] amt,
                          input logic [1:0] op, input logic [31:0] exp, input string tag);
        int cyc;
        start        = 1'b1;
        shift_data   = data;
        shift_amount = amt;
        shift_op     = op;
        tick();
        start        = 1'b0;
        shift_data   = 32'h0;
        shift_amount = 5'd0;
        shift_op     = 2'b00;
        check_eq({tag, "_busy"}, {31'b0, busy}, 32'h1);
        wait_done(0, cyc);
        check_eq({tag, "_lat"}, cyc, 32'(amt) + 32'd1);
        check_eq({tag, "_res"}, result, exp);
        check_eq({tag, "_busy_done"}, {31'b0, busy}, 32'h0);
    endtask

    initial begin
        int  cyc;
        bit  saw_done;

        reset_n      = 1'b0;
        start        = 1'b1;
        shift_data   = 32'hFFFF_FFFF;
        shift_amount = 5'd3;
        shift_op     = 2'b00;
        flush        = 1'b0;

        // Reset held two cycles with Start asserted
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("rst_busy", {31'b0, busy}, 32'h0);
            check_eq("rst_done", {31'b0, done}, 32'h0);
            check_eq("rst_res",  result, 32'h0);
        end
        reset_n = 1'b1;
        start   = 1'b0;
        tick();
        check_eq("rst_rel_busy", {31'b0, busy}, 32'h0);
        check_eq("rst_rel_done", {31'b0, done}, 32'h0);
        check_eq("rst_rel_res",  result, 32'h0);

        // Basic operations
        run_op(32'h0000_00F1, 5'd4, 2'b00, 32'h0000_0F10, "sll4");
        tick();
        check_eq("done_pulse", {31'b0, done}, 32'h0);
        check_eq("res_hold",   result, 32'h0000_0F10);
        run_op(32'h8000_0010, 5'd4, 2'b01, 32'h0800_0001, "srl4");
        run_op(32'h8000_0010, 5'd4, 2'b10, 32'hF800_0001, "sra4");
        run_op(32'hF000_0001, 5'd4, 2'b00, 32'h0000_0010, "sll_lost");
        run_op(32'h8000_0001, 5'd4, 2'b11, 32'h0000_0018, "rotl4");

        // Count boundaries
        run_op(32'hDEAD_BEEF, 5'd0,  2'b01, 32'hDEAD_BEEF, "zero");
        run_op(32'h0000_0001, 5'd31, 2'b11, 32'h8000_0000, "rotl31");
        tick();

        // Start pulsed mid-operation must be ignored
        start = 1'b1; shift_data = 32'h0000_0001; shift_amount = 5'd8; shift_op = 2'b00;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1; shift_data = 32'h0000_FFFF; shift_amount = 5'd2; shift_op = 2'b01;
        tick();
        start = 1'b0;
        wait_done(3, cyc);
        check_eq("ign_lat", cyc, 32'd9);
        check_eq("ign_res", result, 32'h0000_0100);

        // Start in the Done cycle is accepted
        run_op(32'h0000_0003, 5'd1, 2'b00, 32'h0000_0006, "b2b");
        tick();

        // Flush at the third busy cycle of a 10-bit shift
        start = 1'b1; shift_data = 32'h0000_0005; shift_amount = 5'd10; shift_op = 2'b00;
        tick();
        start = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("fl_busy", {31'b0, busy}, 32'h0);
        check_eq("fl_done", {31'b0, done}, 32'h0);
        check_eq("fl_res",  result, 32'h0000_0006);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) saw_done = 1'b1;
        end
        check_eq("fl_no_done", {31'b0, saw_done}, 32'h0);

        // Flush on the completion edge wins over completion
        start = 1'b1; shift_data = 32'h0000_0007; shift_amount = 5'd2; shift_op = 2'b00;
        tick();
        start = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flc_done", {31'b0, done}, 32'h0);
        check_eq("flc_res",  result, 32'h0000_0006);
        check_eq("flc_busy", {31'b0, busy}, 32'h0);

        // Flush beats Start in idle
        flush = 1'b1; start = 1'b1; shift_data = 32'h0000_0001; shift_amount = 5'd1;
        tick();
        flush = 1'b0; start = 1'b0;
        check_eq("fls_busy", {31'b0, busy}, 32'h0);
        tick();
        check_eq("fls_done", {31'b0, done}, 32'h0);

        // Reset at the third busy cycle of a 10-bit shift
        start = 1'b1; shift_data = 32'h0000_0005; shift_amount = 5'd10; shift_op = 2'b00;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_eq("mr_busy", {31'b0, busy}, 32'h0);
        check_eq("mr_done", {31'b0, done}, 32'h0);
        check_eq("mr_res",  result, 32'h0);
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) saw_done = 1'b1;
        end
        check_eq("mr_no_done", {31'b0, saw_done}, 32'h0);

        // Unit still works after the abort
        run_op(32'h0000_0001, 5'd1, 2'b00, 32'h0000_0002, "post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
